umi_mem_mport: RTL and testbench
================================

// Module: umi_mem_mport
// PURPOSE
// - Multi-port UMI device-side memory model: NPORTS independent UMI device ports
//   share one RAMDEPTH x DW array, arbitrated round-robin.
// - Responses return on the originating port after a fixed LATENCY.
// - Successor to the single-port memory agent used behind the AXI/UMI converter
//   benches. All host ports are served, so no chipid/port steering is needed.
// PARAMETERS
// - NPORTS    4     number of UMI device ports (>=1)
// - DW        64    UMI data width, bits (power of 2, >=32)
// - AW        64    UMI address width
// - CW        32    UMI command width
// - RAMDEPTH  4096  array depth in DW-bit words (power of 2)
// - LATENCY   2     request-accept to response-valid delay, cycles (>=1)
// PORTS
// - clk               in   1          clock, all logic on rising edge
// - nreset            in   1          asynchronous active-low reset
// - udev_req_valid    in   NPORTS     per-port request valid
// - udev_req_cmd      in   NPORTS*CW  port i at [i*CW +: CW]
// - udev_req_dstaddr  in   NPORTS*AW  target address
// - udev_req_srcaddr  in   NPORTS*AW  return address
// - udev_req_data     in   NPORTS*DW  write data, LSB-aligned
// - udev_req_ready    out  NPORTS     per-port request ready
// - udev_resp_valid   out  NPORTS     per-port response valid
// - udev_resp_cmd     out  NPORTS*CW  response command
// - udev_resp_dstaddr out  NPORTS*AW  = request srcaddr
// - udev_resp_srcaddr out  NPORTS*AW  = request dstaddr
// - udev_resp_data    out  NPORTS*DW  read data, LSB-aligned; 0 for writes/errors
// - udev_resp_ready   in   NPORTS     per-port response ready
// - stat_reqcnt       out  NPORTS*32  per-port accepted-request counters (see CONFIGURATION)
// BEHAVIOUR
// - Reset (nreset low, asynchronous):
//   - all resp_valid=0; resp cmd/addr/data=0; rr pointer=0; outstanding flags=0;
//     pipeline valids=0; stat_reqcnt=0.
//   - Array contents are not reset.
//   - Reset mid-transaction drops all in-flight requests; no responses are produced.
// - Eligibility: port i is eligible when req_valid[i] & !outstanding[i].
// - Arbitration: one grant per cycle, round-robin.
//   - Search starts at rr pointer; after a grant to port g, pointer <= (g+1) mod NPORTS.
//   - req_ready[i] = grant[i], combinational from valid/outstanding/pointer.
//     Valid must not depend on ready.
// - Command fields: opc=cmd[4:0], size=cmd[7:5], len=cmd[15:8], err=cmd[26:25].
//   - nbytes=(len+1)<<size; off=dstaddr[log2(DW/8)-1:0];
//     word=dstaddr[log2(DW/8) +: log2(RAMDEPTH)]. Upper address bits are ignored.
//   - Legal access: off+nbytes <= DW/8 (single beat); otherwise ERR.
// - Opcodes, executed in the accept cycle T:
//   - REQ_READ 5'h01: read word; data>>(8*off), masked to nbytes. Response RESP_READ 5'h02.
//   - REQ_WRITE 5'h03: byte-masked write of data<<(8*off), bytes [off, off+nbytes).
//     Response RESP_WRITE 5'h04.
//   - REQ_POSTED 5'h05: same write; no response; outstanding stays clear.
//   - Other cmd[0]=1 opcodes, and illegal accesses: no array access.
//     Response RESP_WRITE with err=2'b10.
//   - cmd[0]=0 (response opcodes) on the req channel: accepted, dropped, no response.
// - Response cmd: request cmd with [4:0] replaced and [26:25] set (00 OK, 10 ERR).
// - Timing:
//   - outstanding[g] set at T for responding requests.
//   - Request travels a LATENCY-stage pipeline tagged with g;
//     resp_valid[g] rises at T+LATENCY.
//   - resp_valid held with stable payload until resp_ready; outstanding[g] clears
//     on that handshake. Port g is eligible again the following cycle.
//     Min back-to-back period per port = LATENCY+1 cycles.
// - At most one outstanding response per port, so pipeline exits never collide.
// - A read and a write in consecutive cycles to the same word: the read at T+1
//   sees the write from T.
// CONFIGURATION
// - Macro UMI_MEM_MPORT_STATS_EN.
// - Defined: stat_reqcnt[i*32 +: 32] increments on every accepted request on port i
//   (including posted, dropped, ERR); wraps 2^32-1 -> 0.
// - Undefined: counters are not built; stat_reqcnt is tied to 0.
// TESTING
// - Directed scenarios (NPORTS=4, DW=64, LATENCY=2):
//   - Port0 WRITE size=3 len=0 addr 0x100 data 0x1122334455667788, then READ
//     -> RESP_WRITE err=00 at T+2; RESP_READ data 0x1122334455667788,
//     dstaddr = request srcaddr.
//   - Port2 WRITE size=0 len=1 addr 0x106 data 0xBEEF, then READ size=3 addr 0x100
//     -> upper 2 bytes are 0xBEEF, other bytes unchanged.
//   - All 4 ports issue a READ in the same cycle, pointer=0 -> grants in order
//     0,1,2,3 on consecutive cycles; responses at T+2..T+5.
//   - Port1 holds resp_ready=0 for 10 cycles -> resp payload stable, port1 not
//     granted again; other ports continue to be served.
//   - READ size=3 addr 0x104, and opcode 5'h09 -> RESP with err=2'b10, data 0,
//     array unchanged. POSTED write -> no response.
//   - nreset asserted with 3 requests in flight -> all resp_valid=0 immediately;
//     none emitted after release. STATS_EN build: counters equal accepted-request
//     counts, 0 after reset.

Source files
------------

// File: rtl/umi_mem_mport.sv
// Multi-port UMI device memory: NPORTS device ports share one RAMDEPTH x DW array, round-robin arbitrated.
// Optional per-port accepted-request counters when UMI_MEM_MPORT_STATS_EN is defined.
module umi_mem_mport #(
   parameter int unsigned NPORTS   = 4,
   parameter int unsigned DW       = 64,
   parameter int unsigned AW       = 64,
   parameter int unsigned CW       = 32,
   parameter int unsigned RAMDEPTH = 4096,
   parameter int unsigned LATENCY  = 2
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic [NPORTS-1:0]    udev_req_valid,
   input  logic [NPORTS*CW-1:0] udev_req_cmd,
   input  logic [NPORTS*AW-1:0] udev_req_dstaddr,
   input  logic [NPORTS*AW-1:0] udev_req_srcaddr,
   input  logic [NPORTS*DW-1:0] udev_req_data,
   output logic [NPORTS-1:0]    udev_req_ready,
   output logic [NPORTS-1:0]    udev_resp_valid,
   output logic [NPORTS*CW-1:0] udev_resp_cmd,
   output logic [NPORTS*AW-1:0] udev_resp_dstaddr,
   output logic [NPORTS*AW-1:0] udev_resp_srcaddr,
   output logic [NPORTS*DW-1:0] udev_resp_data,
   input  logic [NPORTS-1:0]    udev_resp_ready,
   output logic [NPORTS*32-1:0] stat_reqcnt
);

   localparam int unsigned BW  = DW / 8;
   localparam int unsigned OW  = $clog2(BW);
   localparam int unsigned IW  = $clog2(RAMDEPTH);
   localparam int unsigned PW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int unsigned NBW = 17;

   localparam logic [4:0] REQ_READ   = 5'h01;
   localparam logic [4:0] RESP_READ  = 5'h02;
   localparam logic [4:0] REQ_WRITE  = 5'h03;
   localparam logic [4:0] RESP_WRITE = 5'h04;
   localparam logic [4:0] REQ_POSTED = 5'h05;

   typedef struct packed {
      logic          vld;
      logic [PW-1:0] port;
      logic [CW-1:0] cmd;
      logic [AW-1:0] dst;
      logic [AW-1:0] src;
      logic [DW-1:0] data;
   } stage_t;

   logic [DW-1:0]   mem [RAMDEPTH];
   logic [PW-1:0]   rr_ptr;
   logic [NPORTS-1:0] outstanding;
   logic [NPORTS-1:0] eligible;
   logic [NPORTS-1:0] grant;
   logic [PW-1:0]   gidx;
   logic [PW-1:0]   idx;
   logic [PW:0]     sum;

   assign eligible       = udev_req_valid & ~outstanding;
   assign udev_req_ready = grant;

   // Round-robin search starting at rr_ptr
   always_comb begin
      grant = '0;
      gidx  = '0;
      idx   = '0;
      sum   = '0;
      for (int unsigned k = 0; k < NPORTS; k++) begin
         sum = {1'b0, rr_ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(NPORTS)) sum = sum - (PW+1)'(NPORTS);
         idx = sum[PW-1:0];
         if (!(|grant) && eligible[idx]) begin
            grant[idx] = 1'b1;
            gidx       = idx;
         end
      end
   end

   logic [CW-1:0]  acc_cmd;
   logic [AW-1:0]  acc_dst;
   logic [AW-1:0]  acc_src;
   logic [DW-1:0]  acc_data;

   assign acc_cmd  = udev_req_cmd[CW*32'(gidx) +: CW];
   assign acc_dst  = udev_req_dstaddr[AW*32'(gidx) +: AW];
   assign acc_src  = udev_req_srcaddr[AW*32'(gidx) +: AW];
   assign acc_data = udev_req_data[DW*32'(gidx) +: DW];

   logic [4:0]     opc;
   logic [2:0]     size;
   logic [7:0]     len;
   logic [NBW-1:0] nbytes;
   logic [OW-1:0]  off;
   logic [IW-1:0]  word;
   logic           legal;
   logic           op_read;
   logic           op_write;
   logic           do_err;
   logic           do_wr;
   logic           respond;

   assign opc      = acc_cmd[4:0];
   assign size     = acc_cmd[7:5];
   assign len      = acc_cmd[15:8];
   assign nbytes   = (NBW'(len) + NBW'(1)) << size;
   assign off      = acc_dst[OW-1:0];
   assign word     = acc_dst[OW +: IW];
   assign legal    = (NBW'(off) + nbytes) <= NBW'(BW);
   assign op_read  = (opc == REQ_READ);
   assign op_write = (opc == REQ_WRITE) || (opc == REQ_POSTED);
   assign do_err   = acc_cmd[0] && (!legal || !(op_read || op_write));
   assign do_wr    = (|grant) && acc_cmd[0] && op_write && legal;
   assign respond  = (|grant) && acc_cmd[0] && (opc != REQ_POSTED);

   logic [DW-1:0] wbits;
   logic [DW-1:0] rbits;
   logic [DW-1:0] wdata_sh;
   logic [DW-1:0] rdata;

   // Byte lanes touched by the access, and read result alignment
   always_comb begin
      wbits = '0;
      rbits = '0;
      for (int unsigned b = 0; b < BW; b++) begin
         wbits[8*b +: 8] = {8{(NBW'(b) >= NBW'(off)) && (NBW'(b) < NBW'(off) + nbytes)}};
         rbits[8*b +: 8] = {8{NBW'(b) < nbytes}};
      end
      wdata_sh = acc_data << {off, 3'b000};
      rdata    = (mem[word] >> {off, 3'b000}) & rbits;
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[word] <= (mem[word] & ~wbits) | (wdata_sh & wbits);
   end

   stage_t acc;
   stage_t pipe_exit;

   always_comb begin
      acc          = '0;
      acc.vld      = respond;
      acc.port     = gidx;
      acc.cmd      = acc_cmd;
      acc.cmd[4:0] = (op_read && !do_err) ? RESP_READ : RESP_WRITE;
      acc.cmd[26:25] = do_err ? 2'b10 : 2'b00;
      acc.dst      = acc_src;
      acc.src      = acc_dst;
      acc.data     = (op_read && !do_err) ? rdata : '0;
   end

   // LATENCY-1 delay stages; the response registers add the final cycle
   if (LATENCY == 1) begin : g_nopipe
      assign pipe_exit = acc;
   end else begin : g_pipe
      stage_t pipe [LATENCY-1];
      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            for (int unsigned k = 0; k < LATENCY-1; k++) pipe[k] <= '0;
         end else begin
            pipe[0] <= acc;
            for (int unsigned k = 1; k < LATENCY-1; k++) pipe[k] <= pipe[k-1];
         end
      end
      assign pipe_exit = pipe[LATENCY-2];
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rr_ptr            <= '0;
         outstanding       <= '0;
         udev_resp_valid   <= '0;
         udev_resp_cmd     <= '0;
         udev_resp_dstaddr <= '0;
         udev_resp_srcaddr <= '0;
         udev_resp_data    <= '0;
      end else begin
         if (|grant) rr_ptr <= (gidx == PW'(NPORTS-1)) ? '0 : gidx + PW'(1);
         for (int unsigned i = 0; i < NPORTS; i++) begin
            if (grant[i] && respond) outstanding[i] <= 1'b1;
            else if (udev_resp_valid[i] && udev_resp_ready[i]) outstanding[i] <= 1'b0;

            if (pipe_exit.vld && (pipe_exit.port == PW'(i))) begin
               udev_resp_valid[i]             <= 1'b1;
               udev_resp_cmd[i*CW +: CW]      <= pipe_exit.cmd;
               udev_resp_dstaddr[i*AW +: AW]  <= pipe_exit.dst;
               udev_resp_srcaddr[i*AW +: AW]  <= pipe_exit.src;
               udev_resp_data[i*DW +: DW]     <= pipe_exit.data;
            end else if (udev_resp_valid[i] && udev_resp_ready[i]) begin
               udev_resp_valid[i] <= 1'b0;
            end
         end
      end
   end

`ifdef UMI_MEM_MPORT_STATS_EN
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         stat_reqcnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NPORTS; i++) begin
            if (grant[i]) stat_reqcnt[i*32 +: 32] <= stat_reqcnt[i*32 +: 32] + 32'd1;
         end
      end
   end
`else
   assign stat_reqcnt = '0;
`endif

endmodule

// File: tb/tb_umi_mem_mport.sv
// Directed bench for umi_mem_mport (NPORTS=4, DW=64, LATENCY=2): vector table plus multi-cycle sequences.
module tb_umi_mem_mport;

   logic         clk = 1'b0;
   logic         nreset;
   logic [3:0]   req_valid;
   logic [127:0] req_cmd;
   logic [255:0] req_dst;
   logic [255:0] req_src;
   logic [255:0] req_data;
   logic [3:0]   req_ready;
   logic [3:0]   resp_valid;
   logic [127:0] resp_cmd;
   logic [255:0] resp_dst;
   logic [255:0] resp_src;
   logic [255:0] resp_data;
   logic [3:0]   resp_ready;
   logic [127:0] stat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   umi_mem_mport #(.NPORTS(4), .DW(64), .AW(64), .CW(32), .RAMDEPTH(4096), .LATENCY(2)) dut (
      .clk(clk), .nreset(nreset),
      .udev_req_valid(req_valid), .udev_req_cmd(req_cmd),
      .udev_req_dstaddr(req_dst), .udev_req_srcaddr(req_src),
      .udev_req_data(req_data), .udev_req_ready(req_ready),
      .udev_resp_valid(resp_valid), .udev_resp_cmd(resp_cmd),
      .udev_resp_dstaddr(resp_dst), .udev_resp_srcaddr(resp_src),
      .udev_resp_data(resp_data), .udev_resp_ready(resp_ready),
      .stat_reqcnt(stat)
   );

   typedef struct {
      logic [1:0]  port;
      logic [31:0] cmd;
      logic [63:0] dst;
      logic [63:0] src;
      logic [63:0] data;
      bit          resp;
      logic [31:0] ecmd;
      logic [63:0] edata;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] opc, input logic [2:0] sz, input logic [7:0] len);
      return {5'b10101, 2'b00, 9'h0A5, len, sz, opc};
   endfunction

   function automatic logic [31:0] rc(input logic [31:0] c, input logic [4:0] opc, input logic [1:0] err);
      logic [31:0] r;
      r = c;
      r[4:0]   = opc;
      r[26:25] = err;
      return r;
   endfunction

   function automatic vec_t mv(input logic [1:0] p, input logic [31:0] c, input logic [63:0] d,
                               input logic [63:0] w, input bit r, input logic [4:0] ropc,
                               input logic [1:0] rerr, input logic [63:0] ed);
      vec_t v;
      v.port = p; v.cmd = c; v.dst = d; v.data = w; v.resp = r;
      v.src  = 64'h5A00_0000_0000_1000 | 64'(p);
      v.ecmd = rc(c, ropc, rerr);
      v.edata = ed;
      return v;
   endfunction

   task automatic drv(input logic [1:0] p, input logic [31:0] c, input logic [63:0] d,
                      input logic [63:0] s, input logic [63:0] w);
      req_cmd[p*32 +: 32]  = c;
      req_dst[p*64 +: 64]  = d;
      req_src[p*64 +: 64]  = s;
      req_data[p*64 +: 64] = w;
      req_valid[p]         = 1'b1;
   endtask

   task automatic apply(input int id, input vec_t v);
      int n;
      @(negedge clk);
      req_valid = '0;
      drv(v.port, v.cmd, v.dst, v.src, v.data);
      #1;
      n = 0;
      while (!req_ready[v.port] && n < 20) begin @(negedge clk); #1; n++; end
      chk($sformatf("v%0d_accept", id), 64'(req_ready[v.port]), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid[v.port] = 1'b0;
      #1;
      if (v.resp) begin
         n = 1;
         while (!resp_valid[v.port] && n < 10) begin @(negedge clk); #1; n++; end
         chk($sformatf("v%0d_latency", id), 64'(n), 64'd2);
         chk($sformatf("v%0d_cmd", id), 64'(resp_cmd[v.port*32 +: 32]), 64'(v.ecmd));
         chk($sformatf("v%0d_data", id), resp_data[v.port*64 +: 64], v.edata);
         chk($sformatf("v%0d_dstaddr", id), resp_dst[v.port*64 +: 64], v.src);
         chk($sformatf("v%0d_srcaddr", id), resp_src[v.port*64 +: 64], v.dst);
      end else begin
         n = 0;
         for (int k = 0; k < 4; k++) begin
            if (resp_valid[v.port]) n++;
            @(negedge clk); #1;
         end
         chk($sformatf("v%0d_no_resp", id), 64'(n), 64'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vec_t vt [17];
      int   exp_cnt [4];
      int   n, bad, g0;
      logic [3:0]  e;
      logic [63:0] cap_data;
      logic [31:0] cap_cmd;

      vt[0]  = mv(0, mk(5'h03,3,0), 64'h100, 64'h1122334455667788, 1, 5'h04, 2'b00, 64'h0);
      vt[1]  = mv(0, mk(5'h01,3,0), 64'h100, 64'h0, 1, 5'h02, 2'b00, 64'h1122334455667788);
      vt[2]  = mv(2, mk(5'h03,0,1), 64'h106, 64'hBEEF, 1, 5'h04, 2'b00, 64'h0);
      vt[3]  = mv(2, mk(5'h01,3,0), 64'h100, 64'h0, 1, 5'h02, 2'b00, 64'hBEEF334455667788);
      vt[4]  = mv(1, mk(5'h01,1,0), 64'h106, 64'h0, 1, 5'h02, 2'b00, 64'hBEEF);
      vt[5]  = mv(3, mk(5'h01,3,0), 64'h104, 64'h0, 1, 5'h04, 2'b10, 64'h0);
      vt[6]  = mv(3, mk(5'h09,3,0), 64'h100, 64'hDEAD, 1, 5'h04, 2'b10, 64'h0);
      vt[7]  = mv(0, mk(5'h01,3,0), 64'h100, 64'h0, 1, 5'h02, 2'b00, 64'hBEEF334455667788);
      vt[8]  = mv(1, mk(5'h05,2,0), 64'h100, 64'hCAFEF00D, 0, 5'h00, 2'b00, 64'h0);
      vt[9]  = mv(1, mk(5'h01,3,0), 64'h100, 64'h0, 1, 5'h02, 2'b00, 64'hBEEF3344CAFEF00D);
      vt[10] = mv(2, mk(5'h02,3,0), 64'h100, 64'h1234, 0, 5'h00, 2'b00, 64'h0);
      vt[11] = mv(0, mk(5'h01,0,3), 64'h104, 64'h0, 1, 5'h02, 2'b00, 64'hBEEF3344);
      vt[12] = mv(3, mk(5'h03,3,0), 64'h7FF8, 64'h0123456789ABCDEF, 1, 5'h04, 2'b00, 64'h0);
      vt[13] = mv(3, mk(5'h01,3,0), 64'hFFFF_0000_0000_7FF8, 64'h0, 1, 5'h02, 2'b00, 64'h0123456789ABCDEF);
      vt[14] = mv(1, mk(5'h03,0,0), 64'h7FFF, 64'hAA, 1, 5'h04, 2'b00, 64'h0);
      vt[15] = mv(0, mk(5'h01,3,0), 64'h7FF8, 64'h0, 1, 5'h02, 2'b00, 64'hAA23456789ABCDEF);
      vt[16] = mv(2, mk(5'h01,2,0), 64'h7FFC, 64'h0, 1, 5'h02, 2'b00, 64'hAA234567);

      nreset = 1'b0;
      req_valid = '0; req_cmd = '0; req_dst = '0; req_src = '0; req_data = '0;
      resp_ready = 4'hF;
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_cmd", resp_cmd[63:0], 64'd0);
      chk("rst_resp_data", resp_data[63:0], 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_stat_lo", stat[63:0], 64'd0);
      chk("rst_stat_hi", stat[127:64], 64'd0);
      @(negedge clk);
      nreset = 1'b1;

      // All four ports request together: grants 0..3, responses two cycles later each
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
         drv(2'(p), mk(5'h01,3,0), 64'h200 + 64'(8*p), 64'h5A00_0000_0000_1000 | 64'(p), 64'h0);
         exp_cnt[p]++;
      end
      for (int k = 0; k < 7; k++) begin
         if (k > 0 && k < 5) req_valid[k-1] = 1'b0;
         #1;
         e = (k < 4) ? (4'b0001 << k) : 4'b0000;
         chk($sformatf("rr_grant_c%0d", k), 64'(req_ready), 64'(e));
         e = (k >= 2 && k < 6) ? (4'b0001 << (k-2)) : 4'b0000;
         chk($sformatf("rr_resp_c%0d", k), 64'(resp_valid), 64'(e));
         @(negedge clk);
      end

      for (int i = 0; i < 17; i++) begin
         apply(i, vt[i]);
         exp_cnt[vt[i].port]++;
      end

      for (int p = 0; p < 4; p++) begin
`ifdef UMI_MEM_MPORT_STATS_EN
         chk($sformatf("stat_p%0d", p), 64'(stat[p*32 +: 32]), 64'(exp_cnt[p]));
`else
         chk($sformatf("stat_p%0d", p), 64'(stat[p*32 +: 32]), 64'd0);
`endif
      end

      // Port1 stalls its response while port0 keeps being served
      resp_ready = 4'b1101;
      @(negedge clk);
      req_valid = '0;
      drv(1, mk(5'h01,3,0), 64'h100, 64'h5A00_0000_0000_1001, 64'h0);
      #1;
      n = 0;
      while (!req_ready[1] && n < 20) begin @(negedge clk); #1; n++; end
      chk("stall_accept", 64'(req_ready[1]), 64'd1);
      @(posedge clk);
      @(negedge clk);
      drv(0, mk(5'h01,3,0), 64'h7FF8, 64'h5A00_0000_0000_1000, 64'h0);
      #1;
      n = 1;
      while (!resp_valid[1] && n < 10) begin @(negedge clk); #1; n++; end
      chk("stall_latency", 64'(n), 64'd2);
      cap_data = resp_data[127:64];
      cap_cmd  = resp_cmd[63:32];
      chk("stall_data", cap_data, 64'hBEEF3344CAFEF00D);
      chk("stall_dstaddr", resp_dst[127:64], 64'h5A00_0000_0000_1001);
      bad = 0;
      g0  = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         if (req_ready[1] || !resp_valid[1] || resp_data[127:64] !== cap_data ||
             resp_cmd[63:32] !== cap_cmd) bad++;
         if (req_ready[0]) g0++;
      end
      chk("stall_hold", 64'(bad), 64'd0);
      chk("stall_p0_served", 64'(g0 >= 3), 64'd1);
      @(negedge clk);
      req_valid[0] = 1'b0;
      resp_ready = 4'hF;
      #1;
      chk("stall_still_busy", 64'(req_ready[1]), 64'd0);
      @(negedge clk); #1;
      chk("stall_resp_drop", 64'(resp_valid[1]), 64'd0);
      chk("stall_regrant", 64'(req_ready[1]), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      repeat (5) @(negedge clk);

      // Reset with three requests in flight
      resp_ready = 4'h0;
      for (int p = 0; p < 3; p++)
         drv(2'(p), mk(5'h01,3,0), 64'h100, 64'h5A00_0000_0000_1000 | 64'(p), 64'h0);
      repeat (3) @(negedge clk);
      #1;
      nreset = 1'b0;
      req_valid = '0;
      #1;
      chk("inflight_rst_valid", 64'(resp_valid), 64'd0);
      chk("inflight_rst_cmd", resp_cmd[63:0], 64'd0);
      chk("inflight_rst_stat", stat[63:0], 64'd0);
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      resp_ready = 4'hF;
      e = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         e = e | resp_valid;
      end
      chk("inflight_no_resp", 64'(e), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
